// File: rtl/branch_predict_resolve.sv
// branch_predict_resolve: zero-latency BEQZ/BNEZ/BLTZ/BGEZ resolve plus a 2-bit saturating BHT.
// Define BRANCH_PERF_CNT_EN to add the perf_branches/perf_mispredicts counters.
module branch_predict_resolve #(
    parameter int DATA_W    = 16,
    parameter int BHT_DEPTH = 16,
    parameter int IDX_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] if_pc,
    output logic              if_pred_taken,
    input  logic              ex_valid,
    input  logic              ex_stall,
    input  logic [4:0]        ex_op,
    input  logic [DATA_W-1:0] ex_pc,
    input  logic [DATA_W-1:0] ex_rs_data,
    input  logic              ex_pred_taken,
    output logic              branch_taken,
    output logic              mispredict,
    output logic              flush_q
`ifdef BRANCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_branches,
    output logic [31:0]       perf_mispredicts
`endif
);
    logic [1:0]       bht [BHT_DEPTH];
    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic [1:0]       cur, nxt;
    logic             is_br, cond;
    logic             unused_bits;
    assign unused_bits = ^{if_pc[DATA_W-1:IDX_W+1], if_pc[0], ex_pc[DATA_W-1:IDX_W+1], ex_pc[0]};
    always_comb begin
        rd_idx        = if_pc[IDX_W:1];
        wr_idx        = ex_pc[IDX_W:1];
        is_br         = ex_valid && !ex_stall && (ex_op[4:2] == 3'b011);
        // op[1] picks sign test vs zero test; op[0] inverts the sense
        cond          = ex_op[0] ^ (ex_op[1] ? ex_rs_data[DATA_W-1] : |ex_rs_data);
        cur           = bht[wr_idx];
        nxt           = cond ? ((cur == 2'b11) ? cur : cur + 2'd1)
                             : ((cur == 2'b00) ? cur : cur - 2'd1);
        branch_taken  = is_br && cond;
        mispredict    = is_br && (cond != ex_pred_taken);
        if_pred_taken = bht[rd_idx][1];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
            flush_q <= 1'b0;
        end else begin
            if (is_br) bht[wr_idx] <= nxt;
            flush_q <= mispredict;
        end
    end
`ifdef BRANCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else begin
            perf_branches    <= perf_branches + {31'd0, is_br && !(&perf_branches)};
            perf_mispredicts <= perf_mispredicts + {31'd0, mispredict && !(&perf_mispredicts)};
        end
    end
`endif
endmodule

// File: tb/tb_branch_predict_resolve.sv
// tb_branch_predict_resolve: randomized + directed checks against a counter-array reference model.
// Define BRANCH_PERF_CNT_EN to also exercise the perf counters.
module tb_branch_predict_resolve;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] if_pc = '0;
    logic        if_pred_taken;
    logic        ex_valid = 1'b0;
    logic        ex_stall = 1'b0;
    logic [4:0]  ex_op = '0;
    logic [15:0] ex_pc = '0;
    logic [15:0] ex_rs_data = '0;
    logic        ex_pred_taken = 1'b0;
    logic        branch_taken, mispredict, flush_q;
`ifdef BRANCH_PERF_CNT_EN
    logic [31:0] perf_branches, perf_mispredicts;
`endif
    int checks = 0;
    int failures = 0;
    int model [16];
    longint exp_br = 0;
    longint exp_mp = 0;

    always #5 clk = ~clk;

    branch_predict_resolve dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_op(ex_op), .ex_pc(ex_pc),
        .ex_rs_data(ex_rs_data), .ex_pred_taken(ex_pred_taken),
        .branch_taken(branch_taken), .mispredict(mispredict), .flush_q(flush_q)
`ifdef BRANCH_PERF_CNT_EN
        , .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
`endif
    );

    // One cycle: drive, check combinational outputs, advance the model at the edge, check registered outputs.
    task automatic step(input logic v, input logic s, input logic [4:0] op, input logic [15:0] pc,
                        input logic [15:0] rs, input logic pr, input logic [15:0] ipc);
        bit br, c, e_tk, e_mp, e_ip;
        int wi;
        @(negedge clk);
        ex_valid = v; ex_stall = s; ex_op = op; ex_pc = pc;
        ex_rs_data = rs; ex_pred_taken = pr; if_pc = ipc;
        #1;
        br = v && !s && (op >= 5'd12 && op <= 5'd15);
        case (op)
            5'd12: c = (rs != 0);
            5'd13: c = (rs == 0);
            5'd14: c = ($signed(rs) < 0);
            default: c = ($signed(rs) >= 0);
        endcase
        e_tk = br && c;
        e_mp = br && (c != pr);
        e_ip = model[(ipc / 2) % 16] >= 2;
        wi = (pc / 2) % 16;
        checks += 3;
        if (branch_taken !== e_tk) begin failures++; $display("FAIL branch_taken op=%0d rs=%h got=%b exp=%b", op, rs, branch_taken, e_tk); end
        if (mispredict !== e_mp) begin failures++; $display("FAIL mispredict op=%0d rs=%h got=%b exp=%b", op, rs, mispredict, e_mp); end
        if (if_pred_taken !== e_ip) begin failures++; $display("FAIL if_pred_taken pc=%h got=%b exp=%b", ipc, if_pred_taken, e_ip); end
        @(posedge clk);
        if (rst) begin
            foreach (model[i]) model[i] = 1;
            exp_br = 0; exp_mp = 0;
        end else begin
            if (br) model[wi] = c ? (model[wi] < 3 ? model[wi] + 1 : 3) : (model[wi] > 0 ? model[wi] - 1 : 0);
            if (br && exp_br < 64'hFFFF_FFFF) exp_br++;
            if (e_mp && exp_mp < 64'hFFFF_FFFF) exp_mp++;
        end
        #1;
        checks++;
        if (flush_q !== (e_mp && !rst)) begin failures++; $display("FAIL flush_q got=%b exp=%b", flush_q, e_mp && !rst); end
`ifdef BRANCH_PERF_CNT_EN
        checks += 2;
        if (perf_branches !== exp_br[31:0]) begin failures++; $display("FAIL perf_branches got=%0d exp=%0d", perf_branches, exp_br); end
        if (perf_mispredicts !== exp_mp[31:0]) begin failures++; $display("FAIL perf_mispredicts got=%0d exp=%0d", perf_mispredicts, exp_mp); end
`endif
    endtask

    task automatic idle(input logic [15:0] ipc);
        step(1'b0, 1'b0, 5'd0, 16'd0, 16'd0, 1'b0, ipc);
    endtask

    task automatic test_reset;
        rst = 1'b1; idle(16'd0); rst = 1'b0;
        for (int i = 0; i < 16; i++) idle(16'(i * 2));
        step(1'b1, 1'b0, 5'd13, 16'h0010, 16'h0000, 1'b0, 16'h0010);
        checks++;
        if (flush_q !== 1'b1) begin failures++; $display("FAIL reset_beqz_flush got=%b exp=1", flush_q); end
        idle(16'h0010);
        checks++;
        if (flush_q !== 1'b0) begin failures++; $display("FAIL reset_flush_pulse got=%b exp=0", flush_q); end
    endtask

    task automatic test_train;
        rst = 1'b1; idle(16'd0); rst = 1'b0;
        repeat (3) step(1'b1, 1'b0, 5'd12, 16'h0006, 16'h0000, 1'b0, 16'h0006);
        step(1'b1, 1'b0, 5'd12, 16'h0006, 16'h0001, 1'b0, 16'h0006);
        step(1'b1, 1'b0, 5'd12, 16'h0006, 16'h0001, 1'b0, 16'h0006);
        idle(16'h0006);
        checks++;
        if (if_pred_taken !== 1'b1) begin failures++; $display("FAIL train_pc6 got=%b exp=1", if_pred_taken); end
    endtask

    task automatic test_conds;
        step(1'b1, 1'b0, 5'd14, 16'h0002, 16'h8000, 1'b0, 16'h0002);
        step(1'b1, 1'b0, 5'd15, 16'h0002, 16'h8000, 1'b1, 16'h0002);
        step(1'b1, 1'b0, 5'd15, 16'h0002, 16'h0000, 1'b0, 16'h0002);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 5'd0, 16'h0002, 16'($urandom), 1'($urandom), 16'h0002);
        step(1'b1, 1'b0, 5'd11, 16'h0002, 16'h0000, 1'b0, 16'h0002);
        step(1'b1, 1'b0, 5'd28, 16'h0002, 16'h8000, 1'b0, 16'h0002);
    endtask

    task automatic test_collision;
        rst = 1'b1; idle(16'd0); rst = 1'b0;
        step(1'b1, 1'b0, 5'd13, 16'h000A, 16'h0000, 1'b0, 16'h000A);
        checks++;
        if (if_pred_taken !== 1'b1) begin failures++; $display("FAIL collision_new got=%b exp=1", if_pred_taken); end
        step(1'b1, 1'b0, 5'd12, 16'h000A, 16'h0000, 1'b1, 16'h000A);
    endtask

    task automatic test_gating;
        rst = 1'b1; idle(16'd0); rst = 1'b0;
        step(1'b1, 1'b1, 5'd13, 16'h0004, 16'h0000, 1'b0, 16'h0004);
        step(1'b0, 1'b0, 5'd13, 16'h0004, 16'h0000, 1'b0, 16'h0004);
        step(1'b1, 1'b0, 5'd13, 16'h0004, 16'h0000, 1'b1, 16'h0004);
        rst = 1'b1;
        step(1'b1, 1'b0, 5'd13, 16'h0004, 16'h0000, 1'b1, 16'h0004);
        rst = 1'b0;
        idle(16'h0004);
        step(1'b1, 1'b0, 5'd13, 16'h0004, 16'h0000, 1'b1, 16'h0004);
        idle(16'h0004);
    endtask

    task automatic test_random;
        logic [15:0] rs;
        logic [4:0]  op;
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            op = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: rs = 16'h0000;
                1: rs = 16'h0001;
                2: rs = 16'h8000;
                default: rs = 16'($urandom);
            endcase
            step(($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0), op,
                 16'($urandom_range(0, 31)), rs, 1'($urandom), 16'($urandom_range(0, 31)));
        end
        rst = 1'b0;
    endtask

`ifdef BRANCH_PERF_CNT_EN
    task automatic test_perf;
        rst = 1'b1; idle(16'd0); rst = 1'b0;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 5'd13, 16'(i * 2), 16'h0000, (i >= 4), 16'd0);
        checks += 2;
        if (perf_branches !== 32'd10) begin failures++; $display("FAIL perf_10 got=%0d exp=10", perf_branches); end
        if (perf_mispredicts !== 32'd4) begin failures++; $display("FAIL perf_4 got=%0d exp=4", perf_mispredicts); end
        rst = 1'b1; idle(16'd0); rst = 1'b0;
        checks++;
        if ((perf_branches | perf_mispredicts) !== 32'd0) begin failures++; $display("FAIL perf_rst got=%0d/%0d exp=0", perf_branches, perf_mispredicts); end
    endtask
`endif

    initial begin
        test_reset;
        test_train;
        test_conds;
        test_collision;
        test_gating;
        test_random;
`ifdef BRANCH_PERF_CNT_EN
        test_perf;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
